// File: rtl/gbox_cfg_sequencer.sv
// Round-robin configuration sequencer: shifts 41-bit GBOX mode words MSB-first into a channel chain and commits with cfg_load.
// Optional illegal-word rejection is built when GBOX_CFG_CHECK_EN is defined.
module gbox_cfg_sequencer #(
    parameter int NUM_REQ = 4,
    parameter int CHAN_W  = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*41-1:0]      req_mode,
    input  logic [NUM_REQ*CHAN_W-1:0]  req_chan,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [NUM_REQ-1:0]         req_err,
    output logic                       cfg_sdo,
    output logic                       cfg_shift_en,
    output logic                       cfg_load,
    output logic [CHAN_W-1:0]          cfg_chan,
    output logic                       busy
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic [GW-1:0]       gnt_q, gnt_d;
    logic [40:0]         shadow_q, shadow_d;
    logic [CHAN_W-1:0]   chan_q, chan_d;
    logic [5:0]          cnt_q, cnt_d;

    logic [GW:0]         arb_sum_s;
    logic [GW:0]         arb_pos_s;
    logic [GW-1:0]       arb_idx_s;
    logic                arb_hit_s;
    logic [40:0]         sel_mode_s;
    logic [CHAN_W-1:0]   sel_chan_s;
    logic                word_bad_s;

`ifdef GBOX_CFG_CHECK_EN
    function automatic logic mode_illegal(input logic [40:0] w);
        return (w[31] & w[30]) | (w[19:18] == 2'b11) | (w[8:7] == 2'b11) | (w[35] & ~w[34]);
    endfunction
    assign word_bad_s = mode_illegal(sel_mode_s);
`else
    assign word_bad_s = 1'b0;
`endif

    // Round-robin pick: scan downward so the last hit is the first set bit at or after the pointer.
    always_comb begin
        arb_hit_s = 1'b0;
        arb_idx_s = '0;
        arb_sum_s = '0;
        arb_pos_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            arb_sum_s = {1'b0, ptr_q} + (GW+1)'(k);
            if (arb_sum_s >= (GW+1)'(NUM_REQ)) begin
                arb_pos_s = arb_sum_s - (GW+1)'(NUM_REQ);
            end else begin
                arb_pos_s = arb_sum_s;
            end
            if (req_valid[arb_pos_s[GW-1:0]]) begin
                arb_hit_s = 1'b1;
                arb_idx_s = arb_pos_s[GW-1:0];
            end else begin
                arb_hit_s = arb_hit_s;
            end
        end
        sel_mode_s = req_mode[int'(arb_idx_s)*41 +: 41];
        sel_chan_s = req_chan[int'(arb_idx_s)*CHAN_W +: CHAN_W];
    end

    // Next-state logic for the sequencer FSM and its datapath registers.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        shadow_d = shadow_q;
        chan_d   = chan_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_hit_s) begin
                    shadow_d = sel_mode_s;
                    chan_d   = sel_chan_s;
                    gnt_d    = arb_idx_s;
                    ptr_d    = (arb_idx_s == GW'(NUM_REQ - 1)) ? '0 : arb_idx_s + 1'b1;
                    cnt_d    = 6'd40;
                    state_d  = word_bad_s ? ST_ERR : ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shadow_d = {shadow_q[39:0], 1'b0};
                if (cnt_q == 6'd0) begin
                    state_d = ST_LOAD;
                end else begin
                    cnt_d   = cnt_q - 6'd1;
                    state_d = ST_SHIFT;
                end
            end
            ST_LOAD: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            shadow_q <= 41'd0;
            chan_q   <= '0;
            cnt_q    <= 6'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            shadow_q <= shadow_d;
            chan_q   <= chan_d;
            cnt_q    <= cnt_d;
        end
    end

    // Output decode; the accept pulse is gated by reset so every output reads 0 while rst_n is low.
    always_comb begin
        req_ready = '0;
        req_done  = '0;
        req_err   = '0;
        if (rst_n && (state_q == ST_IDLE) && arb_hit_s) begin
            req_ready[arb_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
        req_done[gnt_q] = (state_q == ST_DONE);
`ifdef GBOX_CFG_CHECK_EN
        req_err[gnt_q]  = (state_q == ST_ERR);
`endif
        cfg_shift_en = (state_q == ST_SHIFT);
        cfg_sdo      = (state_q == ST_SHIFT) & shadow_q[40];
        cfg_load     = (state_q == ST_LOAD);
        cfg_chan     = chan_q;
        busy         = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_gbox_cfg_sequencer.sv
// Self-checking bench for gbox_cfg_sequencer: randomized requests checked against a transaction-level reference model.
module tb_gbox_cfg_sequencer;
    localparam int NR = 4;
    localparam int CW = 5;
`ifdef GBOX_CFG_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*41-1:0]  req_mode;
    logic [NR*CW-1:0]  req_chan;
    logic [NR-1:0]     req_ready, req_done, req_err;
    logic              cfg_sdo, cfg_shift_en, cfg_load, busy;
    logic [CW-1:0]     cfg_chan;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ref_ptr = 0;
    logic [40:0]   exp_word [NR];
    logic [CW-1:0] exp_chan [NR];

    gbox_cfg_sequencer #(.NUM_REQ(NR), .CHAN_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_mode(req_mode), .req_chan(req_chan),
        .req_ready(req_ready), .req_done(req_done), .req_err(req_err), .cfg_sdo(cfg_sdo),
        .cfg_shift_en(cfg_shift_en), .cfg_load(cfg_load), .cfg_chan(cfg_chan), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int g; int acc; int ones; logic [NR-1:0] mask; logic [40:0] bits;
        int nsh; int sh_first; int load_c; int nload; logic [CW-1:0] chan_l;
        int done_c; int err_c; int stray;
    } obs_t;

    // Reference arbiter: lowest set index at or above the pointer, otherwise lowest set index overall.
    function automatic int ref_pick(input int ptr, input logic [NR-1:0] m);
        for (int i = ptr; i < NR; i++) if (m[i]) return i;
        for (int i = 0; i < ptr; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic bit ref_illegal(input logic [40:0] w);
        bit bad;
        bad = (w[31] && w[30]) || (w[19] && w[18]) || (w[8] && w[7]) || (w[35] && !w[34]);
        return CHK && bad;
    endfunction

    function automatic logic [40:0] rand41();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[40:0];
    endfunction

    function automatic logic [40:0] legalize(input logic [40:0] w);
        logic [40:0] v;
        v = w;
        v[31] = 1'b0; v[19] = 1'b0; v[8] = 1'b0; v[35] = 1'b0;
        return v;
    endfunction

    task automatic set_req(input int i, input logic [40:0] w, input logic [CW-1:0] ch);
        req_mode[i*41 +: 41] = w;
        req_chan[i*CW +: CW] = ch;
        exp_word[i] = w;
        exp_chan[i] = ch;
        req_valid[i] = 1'b1;
    endtask

    // Observe one transaction: wait for an accept, then record the chain traffic until done/err.
    task automatic collect(input logic [NR-1:0] hold, output obs_t o);
        o = '0;
        o.g = -1; o.acc = -1; o.sh_first = -1; o.load_c = -1; o.done_c = -1; o.err_c = -1;
        for (int w = 0; w < 300 && o.g < 0; w++) begin
            #1;
            if (req_ready != '0) begin
                o.ones = $countones(req_ready);
                o.mask = req_valid;
                o.acc  = cyc;
                for (int i = NR - 1; i >= 0; i--) if (req_ready[i]) o.g = i;
            end else begin
                @(posedge clk);
            end
        end
        if (o.g < 0) return;
        for (int c = 1; c <= 60 && o.done_c < 0 && o.err_c < 0; c++) begin
            @(posedge clk); #1;
            if (c == 1 && !hold[o.g]) req_valid[o.g] = 1'b0;
            if (cfg_shift_en) begin
                o.bits = {o.bits[39:0], cfg_sdo};
                o.nsh++;
                if (o.sh_first < 0) o.sh_first = c;
            end else if (cfg_sdo) begin
                o.stray++;
            end
            if (cfg_load) begin
                o.nload++;
                if (o.load_c < 0) begin o.load_c = c; o.chan_l = cfg_chan; end
            end
            if (req_done[o.g]) o.done_c = c;
            if (req_err[o.g]) o.err_c = c;
            if (((req_done | req_err) & ~(NR'(1) << o.g)) != '0) o.stray++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, legalize(rand41()), CW'($urandom_range(0, 31)));
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        n_cmp++; if ((req_done | req_err) !== '0) begin n_bad++; $display("FAIL reset_done_err: got %b/%b want 0", req_done, req_err); end
        n_cmp++; if ({cfg_sdo, cfg_shift_en, cfg_load, cfg_chan} !== '0) begin n_bad++; $display("FAIL reset_cfg: got %b want 0", {cfg_sdo, cfg_shift_en, cfg_load, cfg_chan}); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        ref_ptr = 0;
    endtask

    task automatic test_simultaneous();
        obs_t o;
        int prev_acc;
        int exp_g;
        int ord [5] = '{0, 1, 2, 3, 0};
        prev_acc = -1;
        for (int n = 0; n < 5; n++) begin
            collect('0, o);
            exp_g = ref_pick(ref_ptr, o.mask);
            n_cmp++; if (o.g !== ord[n] || o.g !== exp_g) begin n_bad++; $display("FAIL sim_grant%0d: got %0d want %0d", n, o.g, ord[n]); end
            if (n > 0) begin
                n_cmp++; if (o.acc - prev_acc !== 44) begin n_bad++; $display("FAIL sim_spacing%0d: got %0d want 44", n, o.acc - prev_acc); end
            end
            n_cmp++; if (o.done_c !== 43) begin n_bad++; $display("FAIL sim_done%0d: got %0d want 43", n, o.done_c); end
            if (exp_g >= 0) begin
                n_cmp++; if (o.bits !== exp_word[exp_g]) begin n_bad++; $display("FAIL sim_bits%0d: got %h want %h", n, o.bits, exp_word[exp_g]); end
                ref_ptr = (exp_g + 1) % NR;
            end
            prev_acc = o.acc;
            if (n == 0) req_valid[0] = 1'b1;
        end
        req_valid = '0;
    endtask

    task automatic test_single();
        obs_t o;
        set_req(0, 41'h00_4000_0300, 5'd3);
        collect('0, o);
        n_cmp++; if (o.g !== 0 || o.ones !== 1) begin n_bad++; $display("FAIL single_grant: got %0d (%0d hot) want 0 (1 hot)", o.g, o.ones); end
        n_cmp++; if (o.sh_first !== 1 || o.nsh !== 41) begin n_bad++; $display("FAIL single_shift: got first %0d n %0d want 1/41", o.sh_first, o.nsh); end
        n_cmp++; if (o.bits !== 41'h00_4000_0300) begin n_bad++; $display("FAIL single_bits: got %h want 0040000300", o.bits); end
        n_cmp++; if (o.load_c !== 42 || o.nload !== 1) begin n_bad++; $display("FAIL single_load: got %0d x%0d want 42 x1", o.load_c, o.nload); end
        n_cmp++; if (o.chan_l !== 5'd3) begin n_bad++; $display("FAIL single_chan: got %0d want 3", o.chan_l); end
        n_cmp++; if (o.done_c !== 43 || o.stray !== 0) begin n_bad++; $display("FAIL single_done: got %0d stray %0d want 43/0", o.done_c, o.stray); end
        ref_ptr = 1;
    endtask

    task automatic test_illegal();
        obs_t o;
        logic [40:0] w;
        bit bad;
        w = 41'h00_C000_0000;
        bad = ref_illegal(w);
        set_req(2, w, 5'd7);
        collect('0, o);
        n_cmp++; if (o.err_c !== (bad ? 1 : -1)) begin n_bad++; $display("FAIL ill_err: got %0d want %0d", o.err_c, bad ? 1 : -1); end
        n_cmp++; if (o.done_c !== (bad ? -1 : 43)) begin n_bad++; $display("FAIL ill_done: got %0d want %0d", o.done_c, bad ? -1 : 43); end
        n_cmp++; if (o.nsh !== (bad ? 0 : 41) || o.nload !== (bad ? 0 : 1)) begin n_bad++; $display("FAIL ill_chain: got shift %0d load %0d", o.nsh, o.nload); end
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ill_busy_after: got %b want 0", busy); end
        ref_ptr = 3;
    endtask

    task automatic test_zeroed();
        obs_t o;
        set_req(3, 41'd0, 5'd31);
        collect('0, o);
        n_cmp++; if (o.g !== ref_pick(ref_ptr, 4'b1000)) begin n_bad++; $display("FAIL zero_grant: got %0d want 3", o.g); end
        n_cmp++; if (o.bits !== 41'd0 || o.stray !== 0 || o.nsh !== 41) begin n_bad++; $display("FAIL zero_sdo: got %h stray %0d n %0d want 0/0/41", o.bits, o.stray, o.nsh); end
        n_cmp++; if (o.load_c !== 42 || o.chan_l !== 5'd31) begin n_bad++; $display("FAIL zero_load: got %0d chan %0d want 42/31", o.load_c, o.chan_l); end
        ref_ptr = 0;
    endtask

    task automatic test_fairness();
        obs_t o;
        int exp_g;
        int prev_g;
        prev_g = -1;
        set_req(1, legalize(rand41()), 5'd1);
        set_req(2, legalize(rand41()), 5'd2);
        for (int n = 0; n < 4; n++) begin
            collect(4'b0110, o);
            exp_g = ref_pick(ref_ptr, o.mask);
            n_cmp++; if (o.g !== exp_g || o.g === prev_g) begin n_bad++; $display("FAIL fair_grant%0d: got %0d want %0d", n, o.g, exp_g); end
            n_cmp++; if (o.done_c !== 43) begin n_bad++; $display("FAIL fair_done%0d: got %0d want 43", n, o.done_c); end
            if (exp_g >= 0) ref_ptr = (exp_g + 1) % NR;
            prev_g = o.g;
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        obs_t o;
        int exp_g;
        bit bad;
        logic [NR-1:0] m;
        for (int it = 0; it < 6; it++) begin
            m = NR'($urandom_range(1, 15));
            for (int i = 0; i < NR; i++) begin
                if (m[i]) set_req(i, ($urandom_range(0, 1) != 0) ? rand41() : legalize(rand41()), CW'($urandom_range(0, 31)));
            end
            for (int n = 0; n < $countones(m); n++) begin
                collect('0, o);
                exp_g = ref_pick(ref_ptr, o.mask);
                n_cmp++; if (o.g !== exp_g || o.ones !== 1) begin n_bad++; $display("FAIL rnd_grant: got %0d want %0d", o.g, exp_g); end
                if (exp_g < 0) break;
                bad = ref_illegal(exp_word[exp_g]);
                n_cmp++; if (o.bits !== (bad ? 41'd0 : exp_word[exp_g])) begin n_bad++; $display("FAIL rnd_bits: got %h want %h", o.bits, exp_word[exp_g]); end
                n_cmp++; if (o.load_c !== (bad ? -1 : 42) || o.chan_l !== (bad ? CW'(0) : exp_chan[exp_g])) begin n_bad++; $display("FAIL rnd_load: got %0d chan %0d", o.load_c, o.chan_l); end
                n_cmp++; if (o.done_c !== (bad ? -1 : 43) || o.err_c !== (bad ? 1 : -1) || o.stray !== 0) begin n_bad++; $display("FAIL rnd_end: got done %0d err %0d stray %0d", o.done_c, o.err_c, o.stray); end
                ref_ptr = (exp_g + 1) % NR;
            end
            req_valid = '0;
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int t;
        int nl;
        int ns;
        t = -1; nl = 0; ns = 0;
        set_req(1, legalize(rand41()), 5'd9);
        for (int w = 0; w < 300 && t < 0; w++) begin
            #1;
            if (req_ready[1]) t = cyc; else @(posedge clk);
        end
        n_cmp++; if (t < 0) begin n_bad++; $display("FAIL rst_accept: got none want req 1"); end
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 1) req_valid[1] = 1'b0;
            if (cfg_load) nl++;
            if (cfg_shift_en) ns++;
        end
        n_cmp++; if (ns !== 20) begin n_bad++; $display("FAIL rst_pre_shift: got %0d want 20", ns); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({req_ready, req_done, req_err, cfg_sdo, cfg_shift_en, cfg_load, cfg_chan, busy} !== '0) begin
            n_bad++; $display("FAIL rst_async_outputs: got %b want 0", {req_ready, req_done, req_err, cfg_sdo, cfg_shift_en, cfg_load, cfg_chan, busy});
        end
        repeat (3) begin @(posedge clk); #1; if (cfg_load) nl++; end
        @(negedge clk);
        rst_n = 1'b1;
        ref_ptr = 0;
        set_req(0, legalize(rand41()), 5'd12);
        set_req(2, legalize(rand41()), 5'd20);
        for (int n = 0; n < 2; n++) begin
            collect('0, o);
            if (o.load_c >= 0 && o.load_c < 42) nl++;
            n_cmp++; if (o.g !== ref_pick(ref_ptr, o.mask)) begin n_bad++; $display("FAIL rst_post_grant%0d: got %0d want %0d", n, o.g, ref_pick(ref_ptr, o.mask)); end
            n_cmp++; if (o.done_c !== 43 || o.bits !== exp_word[(n == 0) ? 0 : 2]) begin n_bad++; $display("FAIL rst_post_txn%0d: got done %0d bits %h", n, o.done_c, o.bits); end
            ref_ptr = (ref_pick(ref_ptr, o.mask) + 1) % NR;
        end
        n_cmp++; if (nl !== 0) begin n_bad++; $display("FAIL rst_no_load: got %0d early loads want 0", nl); end
        req_valid = '0;
    endtask

    initial begin
        req_valid = '0;
        req_mode  = '0;
        req_chan  = '0;
        rst_n     = 1'b0;
        test_reset();
        test_simultaneous();
        test_single();
        test_illegal();
        test_zeroed();
        test_fairness();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
